// File: rtl/rule_scheduler_if.sv
// Scheduler <-> network_logic / trace-buffer bus: rule selection, state
// feedback, commit strobe and the per-round valid/ready handshake.
interface rule_scheduler_if #(
    parameter int RULES     = 61,
    parameter int LOG_RULES = 6
);
    logic [LOG_RULES-1:0] rule;
    logic [RULES-1:0]     current_state;
    logic [RULES-1:0]     next_state;
    logic                 rule_commit;
    logic                 round_valid;
    logic                 round_ready;

    modport master (
        output rule,
        output current_state,
        output rule_commit,
        output round_valid,
        input  next_state,
        input  round_ready
    );

    modport slave (
        input  rule,
        input  current_state,
        input  rule_commit,
        input  round_valid,
        output next_state,
        output round_ready
    );
endinterface

// File: rtl/rule_scheduler.sv
// Sequential random-order rule scheduler: applies every rule index once per
// round in LFSR-chosen order, commits next_state, and hands off each round.
module rule_scheduler #(
    parameter int RULES      = 61,
    parameter int RULE_COUNT = 38,
    parameter int LOG_RULES  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [RULES-1:0]     init_state,
    input  logic [15:0]          num_rounds,
    input  logic [15:0]          seed,
    rule_scheduler_if.master     bus,
    output logic [15:0]          rounds_done,
    output logic                 busy,
    output logic                 done
);
    localparam int CNT_W = LOG_RULES + 1;
    localparam logic [LOG_RULES-1:0] RC_IDX    = LOG_RULES'(RULE_COUNT);
    localparam logic [LOG_RULES-1:0] LAST_IDX  = LOG_RULES'(RULE_COUNT - 1);
    localparam logic [CNT_W-1:0]     RC_CNT    = CNT_W'(RULE_COUNT);
    localparam logic [15:0]          LFSR_INIT = 16'hACE1;
    localparam logic [15:0]          LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_PROBE,
        S_APPLY,
        S_CAPTURE,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [15:0]           lfsr_reg, lfsr_next;
    logic [RULE_COUNT-1:0] used_reg, used_next;
    logic [CNT_W-1:0]      applied_reg, applied_next;
    logic [LOG_RULES-1:0]  idx_reg, idx_next;
    logic [LOG_RULES-1:0]  rule_reg, rule_next;
    logic [RULES-1:0]      cur_reg, cur_next;
    logic [15:0]           rounds_reg, rounds_next;
    logic [15:0]           rounds_done_reg, rounds_done_next;

    logic                  commit_c;
    logic                  round_valid_c;
    logic                  done_c;

    logic [LOG_RULES-1:0]  pick_raw;
    logic [LOG_RULES-1:0]  pick_idx;
    logic [LOG_RULES-1:0]  probe_idx;
    logic                  pick_used;
    logic                  probe_used;
    logic [15:0]           lfsr_step;
    logic [CNT_W-1:0]      applied_inc;
    logic [15:0]           rounds_done_inc;
    logic [RULE_COUNT-1:0] idx_onehot;

    // Raw LFSR bits span 2^LOG_RULES values; a single conditional subtract
    // folds them into range because 2^LOG_RULES <= 2*RULE_COUNT.
    assign pick_raw  = lfsr_reg[LOG_RULES-1:0];
    assign pick_idx  = (pick_raw >= RC_IDX) ? (pick_raw - RC_IDX) : pick_raw;
    assign probe_idx = (idx_reg == LAST_IDX) ? '0 : (idx_reg + 1'b1);
    assign pick_used  = used_reg[pick_idx];
    assign probe_used = used_reg[probe_idx];

    assign lfsr_step       = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);
    assign applied_inc     = applied_reg + 1'b1;
    assign rounds_done_inc = rounds_done_reg + 16'd1;

    generate
        for (genvar gi = 0; gi < RULE_COUNT; gi++) begin : g_onehot
            assign idx_onehot[gi] = (idx_reg == LOG_RULES'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            lfsr_reg        <= LFSR_INIT;
            used_reg        <= '0;
            applied_reg     <= '0;
            idx_reg         <= '0;
            rule_reg        <= '0;
            cur_reg         <= '0;
            rounds_reg      <= '0;
            rounds_done_reg <= '0;
        end else begin
            state_reg       <= state_next;
            lfsr_reg        <= lfsr_next;
            used_reg        <= used_next;
            applied_reg     <= applied_next;
            idx_reg         <= idx_next;
            rule_reg        <= rule_next;
            cur_reg         <= cur_next;
            rounds_reg      <= rounds_next;
            rounds_done_reg <= rounds_done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        lfsr_next        = lfsr_reg;
        used_next        = used_reg;
        applied_next     = applied_reg;
        idx_next         = idx_reg;
        rule_next        = rule_reg;
        cur_next         = cur_reg;
        rounds_next      = rounds_reg;
        rounds_done_next = rounds_done_reg;
        commit_c         = 1'b0;
        round_valid_c    = 1'b0;
        done_c           = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    cur_next         = init_state;
                    rounds_next      = num_rounds;
                    lfsr_next        = (seed == 16'h0000) ? LFSR_INIT : seed;
                    rounds_done_next = '0;
                    used_next        = '0;
                    applied_next     = '0;
                    state_next       = (num_rounds == 16'h0000) ? S_DONE : S_PICK;
                end
            end
            S_PICK: begin
                lfsr_next = lfsr_step;
                idx_next  = pick_idx;
                if (!pick_used) begin
                    rule_next  = pick_idx;
                    state_next = S_APPLY;
                end else begin
                    state_next = S_PROBE;
                end
            end
            S_PROBE: begin
                idx_next = probe_idx;
                if (!probe_used) begin
                    rule_next  = probe_idx;
                    state_next = S_APPLY;
                end
            end
            S_APPLY: begin
                // network_logic latches its registered fields this cycle
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                commit_c     = 1'b1;
                cur_next     = bus.next_state;
                used_next    = used_reg | idx_onehot;
                applied_next = applied_inc;
                state_next   = (applied_inc == RC_CNT) ? S_ROUND : S_PICK;
            end
            S_ROUND: begin
                round_valid_c = 1'b1;
                if (bus.round_ready) begin
                    rounds_done_next = rounds_done_inc;
                    used_next        = '0;
                    applied_next     = '0;
                    state_next       = (rounds_done_inc == rounds_reg) ? S_DONE : S_PICK;
                end
            end
            S_DONE: begin
                done_c     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.rule          = rule_reg;
    assign bus.current_state = cur_reg;
    assign bus.rule_commit   = commit_c;
    assign bus.round_valid   = round_valid_c;
    assign rounds_done       = rounds_done_reg;
    // The DONE cycle already reports idle so busy falls with the done pulse.
    assign busy              = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done              = done_c;
endmodule

// File: tb/tb_rule_scheduler.sv
// Bench for rule_scheduler: table-driven runs plus random runs, each checked
// against a loop-level model of the per-round random permutation.
module tb_rule_scheduler;
    localparam int RC     = 38;
    localparam int BUDGET = 8000;

    typedef struct {
        logic [15:0] seed;
        logic [15:0] nr;
        logic [60:0] init;
        int          waitc;
        int          disturb;
        int          exp_commits;
        int          exp_rounds;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [60:0] init_state;
    logic [15:0] num_rounds;
    logic [15:0] seed;
    logic [15:0] rounds_done;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;
    int exp_q[$];
    int got_q[$];
    int seq_a[$];
    logic [60:0] exp_state;
    logic [60:0] st_a;
    vec_t tbl[6];

    rule_scheduler_if #(.RULES(61), .LOG_RULES(6)) bus ();

    rule_scheduler #(.RULES(61), .RULE_COUNT(RC), .LOG_RULES(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .init_state (init_state),
        .num_rounds (num_rounds),
        .seed       (seed),
        .bus        (bus.master),
        .rounds_done(rounds_done),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in network_logic: order-dependent so any reordering shows up.
    function automatic logic [60:0] net_fn(input logic [60:0] s, input logic [5:0] r);
        return {s[59:0], s[60]} ^ (61'd1 << r);
    endfunction

    assign bus.next_state = net_fn(bus.current_state, bus.rule);

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_run(input logic [15:0] s, input logic [15:0] nr, input logic [60:0] init);
        logic [15:0] l;
        int c;
        bit used[RC];
        l = (s == 16'h0000) ? 16'hACE1 : s;
        exp_state = init;
        exp_q.delete();
        for (int r = 0; r < int'(nr); r++) begin
            for (int u = 0; u < RC; u++) used[u] = 1'b0;
            for (int k = 0; k < RC; k++) begin
                c = int'(l) % 64;
                if (c >= RC) c = c - RC;
                l = lfsr_adv(l);
                while (used[c]) c = (c + 1) % RC;
                used[c] = 1'b1;
                exp_q.push_back(c);
                exp_state = net_fn(exp_state, 6'(c));
            end
        end
    endtask

    task automatic chk(input int tag, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL run%0d %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic chk_reset(input int tag);
        chk(tag, "rst_rule",        64'(bus.rule),          64'd0);
        chk(tag, "rst_state",       64'(bus.current_state), 64'd0);
        chk(tag, "rst_commit",      64'(bus.rule_commit),   64'd0);
        chk(tag, "rst_round_valid", 64'(bus.round_valid),   64'd0);
        chk(tag, "rst_rounds_done", 64'(rounds_done),       64'd0);
        chk(tag, "rst_busy",        64'(busy),              64'd0);
        chk(tag, "rst_done",        64'(done),              64'd0);
    endtask

    task automatic run_case(input int tag, input vec_t v);
        int cyc, rv_n, handshakes, commits, done_cyc;
        int stable_bad, rvlen_bad, overlap_bad, mism, perm_bad;
        bit finished;
        bit seen[RC];
        logic [60:0] held;
        cyc = 0; rv_n = 0; handshakes = 0; commits = 0; done_cyc = -1;
        stable_bad = 0; rvlen_bad = 0; overlap_bad = 0; mism = 0; perm_bad = 0;
        finished = 1'b0; held = '0;
        got_q.delete();
        model_run(v.seed, v.nr, v.init);

        @(negedge clk);
        start = 1'b1; seed = v.seed; num_rounds = v.nr; init_state = v.init;
        bus.round_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; seed = ~v.seed; num_rounds = v.nr + 16'd7; init_state = ~v.init;
        cyc = 1;
        chk(tag, "busy_after_start", 64'(busy), 64'(v.nr != 16'd0));
        chk(tag, "rounds_done_clear", 64'(rounds_done), 64'd0);

        while (cyc < BUDGET) begin
            if (bus.rule_commit) begin
                got_q.push_back(int'(bus.rule));
                commits++;
                if (bus.round_valid) overlap_bad++;
            end
            if (bus.round_valid) begin
                rv_n++;
                if (rv_n == 1) held = bus.current_state;
                else if (bus.current_state !== held) stable_bad++;
                bus.round_ready = (rv_n > v.waitc);
                if (bus.round_ready) begin
                    handshakes++;
                    if (rv_n != v.waitc + 1) rvlen_bad++;
                end
            end else begin
                rv_n = 0;
                bus.round_ready = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1'b1;
                break;
            end
            start = (cyc == v.disturb);
            if (start) begin
                seed = v.seed ^ 16'h5A5A;
                num_rounds = v.nr + 16'd3;
                init_state = 61'({$urandom(), $urandom()});
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        bus.round_ready = 1'b0;

        chk(tag, "done_within_budget", 64'(finished), 64'd1);
        if (v.nr == 16'd0) chk(tag, "done_latency", 64'(done_cyc), 64'd1);
        chk(tag, "busy_at_done", 64'(busy), 64'd0);
        chk(tag, "commit_count", 64'(commits), 64'(v.exp_commits));
        if (got_q.size() != exp_q.size()) mism++;
        else for (int i = 0; i < exp_q.size(); i++) if (got_q[i] != exp_q[i]) mism++;
        chk(tag, "rule_sequence", 64'(mism), 64'd0);
        for (int r = 0; r < got_q.size() / RC; r++) begin
            for (int u = 0; u < RC; u++) seen[u] = 1'b0;
            for (int k = 0; k < RC; k++) begin
                if (got_q[r*RC+k] >= 0 && got_q[r*RC+k] < RC) seen[got_q[r*RC+k]] = 1'b1;
            end
            for (int u = 0; u < RC; u++) if (!seen[u]) perm_bad++;
        end
        chk(tag, "permutation", 64'(perm_bad), 64'd0);
        chk(tag, "final_state", 64'(bus.current_state), 64'(exp_state));
        chk(tag, "rounds_done", 64'(rounds_done), 64'(v.exp_rounds));
        chk(tag, "handshakes", 64'(handshakes), 64'(v.nr));
        chk(tag, "round_valid_len", 64'(rvlen_bad), 64'd0);
        chk(tag, "state_stable_wait", 64'(stable_bad), 64'd0);
        chk(tag, "commit_in_round", 64'(overlap_bad), 64'd0);
        @(negedge clk);
        chk(tag, "done_one_cycle", 64'(done), 64'd0);
        chk(tag, "idle_busy", 64'(busy), 64'd0);
        chk(tag, "state_hold", 64'(bus.current_state), 64'(exp_state));
        chk(tag, "rounds_done_hold", 64'(rounds_done), 64'(v.exp_rounds));
        $display("[TB] run %0d seed=%04h rounds=%0d wait=%0d commits=%0d done_cyc=%0d",
                 tag, v.seed, v.nr, v.waitc, commits, done_cyc);
    endtask

    initial begin
        vec_t rv;
        n_tests = 0;
        n_fail  = 0;
        tbl[0] = '{16'h1234, 16'd1, 61'h0123_4567_89AB_CDEF, 0, -1,  38, 1};
        tbl[1] = '{16'h0000, 16'd1, 61'h1555_0000_FFFF_1234, 0, -1,  38, 1};
        tbl[2] = '{16'hACE1, 16'd1, 61'h1555_0000_FFFF_1234, 0, -1,  38, 1};
        tbl[3] = '{16'h5555, 16'd3, 61'h0F0F_F0F0_1234_5678, 5, -1, 114, 3};
        tbl[4] = '{16'h0007, 16'd0, 61'h1DEA_DBEE_F000_0001, 0, -1,   0, 0};
        tbl[5] = '{16'h9999, 16'd2, 61'h0000_0000_0000_0001, 1,  3,  76, 2};

        reset = 1'b1; start = 1'b0; seed = '0; num_rounds = '0; init_state = '0;
        bus.round_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset(100);
        reset = 1'b0;

        // Reset in the middle of a run discards it entirely.
        @(negedge clk);
        start = 1'b1; seed = 16'h4321; num_rounds = 16'd2; init_state = 61'h0ABC_DEF0_1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk(101, "busy_midrun", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_reset(101);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_case(i, tbl[i]);
            if (i == 1) begin
                seq_a = got_q;
                st_a  = bus.current_state;
            end
            if (i == 2) begin
                int d;
                d = (seq_a.size() == got_q.size()) ? 0 : 1;
                if (d == 0) for (int k = 0; k < got_q.size(); k++) if (seq_a[k] != got_q[k]) d++;
                chk(i, "seed0_vs_ace1_seq", 64'(d), 64'd0);
                chk(i, "seed0_vs_ace1_state", 64'(bus.current_state), 64'(st_a));
            end
        end

        for (int i = 0; i < 4; i++) begin
            rv.seed        = 16'($urandom());
            rv.nr          = 16'($urandom_range(1, 2));
            rv.init        = 61'({$urandom(), $urandom()});
            rv.waitc       = int'($urandom_range(0, 3));
            rv.disturb     = (i % 2 == 0) ? int'($urandom_range(2, 40)) : -1;
            rv.exp_commits = RC * int'(rv.nr);
            rv.exp_rounds  = int'(rv.nr);
            run_case(10 + i, rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
